// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a five-stage in-order pipeline.
// A shadow tracker follows the destination info of the instructions in EXE,
// MEM and WB. From it the unit derives the load-use stall, the branch flush
// and the registered ALU operand selects for the instruction entering EXE.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       ID_RD,
    input  logic             ID_REG_WRITE,
    input  logic             ID_MEM_READ,
    input  logic             ID_VALID,
    input  logic             EXE_BRANCH_TAKEN,
    output logic             STALL_PC,
    output logic             STALL_IFID,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEXE,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } entry_t;

    localparam int EXE = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    // WB entry is kept for pipeline bookkeeping only; the register file is
    // write-before-read, so it never feeds a forward.
    entry_t           trk_q [3];
    entry_t           exe_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic exe_prod;
    logic mem_prod;
    logic load_use;
    logic stall_event;
    logic bubble;

    // A producer must be a live instruction writing a register other than x0.
    assign exe_prod = trk_q[EXE].valid & trk_q[EXE].reg_write & (trk_q[EXE].rd != 5'd0);
    assign mem_prod = trk_q[MEM].valid & trk_q[MEM].reg_write & (trk_q[MEM].rd != 5'd0);

    assign load_use = ID_VALID & exe_prod & trk_q[EXE].mem_read &
                      ((ID_USES_RS1 & (ID_RS1 == trk_q[EXE].rd)) |
                       (ID_USES_RS2 & (ID_RS2 == trk_q[EXE].rd)));

    // Stall/flush decode; a taken branch squashes the load-use consumer anyway.
    always_comb begin
        STALL_PC    = 1'b0;
        STALL_IFID  = 1'b0;
        FLUSH_IFID  = 1'b0;
        FLUSH_IDEXE = 1'b0;
        if (rst) begin
            if (EXE_BRANCH_TAKEN) begin
                FLUSH_IFID  = 1'b1;
                FLUSH_IDEXE = 1'b1;
            end else if (load_use) begin
                STALL_PC    = 1'b1;
                STALL_IFID  = 1'b1;
                FLUSH_IDEXE = 1'b1;
            end
        end
    end

    assign stall_event = rst & load_use & ~EXE_BRANCH_TAKEN;
    assign bubble      = ~ID_VALID | FLUSH_IDEXE;

    // Next EXE entry: the ID instruction, or an all-zero bubble.
    always_comb begin
        exe_d = '0;
        if (!bubble) begin
            exe_d.valid     = 1'b1;
            exe_d.rd        = ID_RD;
            exe_d.reg_write = ID_REG_WRITE;
            exe_d.mem_read  = ID_MEM_READ;
        end
    end

    // Operand selects for the instruction about to enter EXE; the younger
    // producer (currently in EXE) wins over the one in MEM.
    always_comb begin
        fwd_a_d = SEL_IDEX;
        fwd_b_d = SEL_IDEX;
        if (!bubble) begin
            if (ID_USES_RS1 && exe_prod && (ID_RS1 == trk_q[EXE].rd))
                fwd_a_d = SEL_EXMEM;
            else if (ID_USES_RS1 && mem_prod && (ID_RS1 == trk_q[MEM].rd))
                fwd_a_d = SEL_MEMWB;
            if (ID_USES_RS2 && exe_prod && (ID_RS2 == trk_q[EXE].rd))
                fwd_b_d = SEL_EXMEM;
            else if (ID_USES_RS2 && mem_prod && (ID_RS2 == trk_q[MEM].rd))
                fwd_b_d = SEL_MEMWB;
        end
    end

    // Saturating load-use stall counter.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_event && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Tracker shifts every cycle; it never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_q[EXE] <= '0;
            trk_q[MEM] <= '0;
            trk_q[WB]  <= '0;
            fwd_a_q    <= SEL_IDEX;
            fwd_b_q    <= SEL_IDEX;
            cnt_q      <= '0;
        end else begin
            trk_q[WB]  <= trk_q[MEM];
            trk_q[MEM] <= trk_q[EXE];
            trk_q[EXE] <= exe_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign FWD_A     = fwd_a_q;
    assign FWD_B     = fwd_b_q;
    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_u1 = 1'b0, id_u2 = 1'b0, id_rw = 1'b0, id_mr = 1'b0;
    logic          id_valid = 1'b0, br = 1'b0;
    logic          stall_pc, stall_ifid, flush_ifid, flush_idexe;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    hazard_fwd_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst_n),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_u1), .ID_USES_RS2(id_u2),
        .ID_RD(id_rd), .ID_REG_WRITE(id_rw), .ID_MEM_READ(id_mr),
        .ID_VALID(id_valid), .EXE_BRANCH_TAKEN(br),
        .STALL_PC(stall_pc), .STALL_IFID(stall_ifid),
        .FLUSH_IFID(flush_ifid), .FLUSH_IDEXE(flush_idexe),
        .FWD_A(fwd_a), .FWD_B(fwd_b), .STALL_CNT(stall_cnt)
    );

    always #5 clk = ~clk;

    wire [3:0] ctl = {stall_pc, stall_ifid, flush_ifid, flush_idexe};

    // Reference model: a record per in-flight instruction, by pipeline stage.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ins_t;

    ins_t   m_exe, m_mem;
    bit [1:0] m_fa, m_fb;
    int     m_cnt;

    function automatic bit writes_reg(ins_t e);
        return e.v && e.rw && (e.rd != 0);
    endfunction

    function automatic bit m_load_use();
        return id_valid && writes_reg(m_exe) && m_exe.mr &&
               ((id_u1 && id_rs1 == m_exe.rd) || (id_u2 && id_rs2 == m_exe.rd));
    endfunction

    // {STALL_PC, STALL_IFID, FLUSH_IFID, FLUSH_IDEXE}
    function automatic logic [3:0] m_ctl();
        if (!rst_n) return 4'b0000;
        if (br) return 4'b0011;
        if (m_load_use()) return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic bit [1:0] m_src(bit uses, bit [4:0] rs);
        if (uses && writes_reg(m_exe) && rs == m_exe.rd) return 2'd1;
        if (uses && writes_reg(m_mem) && rs == m_mem.rd) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        m_exe = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endtask

    task automatic set_id(bit v, bit [4:0] rd, bit rw, bit mr,
                          bit u1, bit [4:0] rs1, bit u2, bit [4:0] rs2, bit b);
        id_valid = v; id_rd = rd; id_rw = rw; id_mr = mr;
        id_u1 = u1; id_rs1 = rs1; id_u2 = u2; id_rs2 = rs2; br = b;
        #1;
    endtask

    // One clock edge; the model advances with the same inputs.
    task automatic tick();
        bit   stall, squash;
        ins_t nxt;
        stall  = m_load_use() && !br;
        squash = !id_valid || br || stall;
        nxt    = squash ? '{0, 0, 0, 0} : '{1, id_rd, id_rw, id_mr};
        m_fa   = squash ? 2'd0 : m_src(id_u1, id_rs1);
        m_fb   = squash ? 2'd0 : m_src(id_u2, id_rs2);
        if (stall && m_cnt < CMAX) m_cnt++;
        m_mem = m_exe;
        m_exe = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_id(1, 5, 1, 1, 1, 5, 1, 5, 1);
        rst_n = 1'b0;
        model_clear();
        #2;
        vec_cnt++;
        if (ctl !== 4'b0000 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_state: ctl=%b fa=%b fb=%b cnt=%0d, want 0000 00 00 0", ctl, fwd_a, fwd_b, stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 5, 1, 1, 0, 0, 0, 0, 0);          // lw x5
        tick();
        set_id(1, 6, 1, 0, 1, 5, 1, 7, 0);          // add x6,x5,x7
        vec_cnt++;
        if (ctl !== 4'b1101) begin
            err_cnt++; $display("FAIL lu_stall: ctl=%b want 1101", ctl);
        end
        tick();
        vec_cnt++;
        if (stall_cnt !== 3'd1 || ctl !== 4'b0000) begin
            err_cnt++; $display("FAIL lu_once: cnt=%0d ctl=%b want 1 0000", stall_cnt, ctl);
        end
        tick();
        vec_cnt++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            err_cnt++; $display("FAIL lu_fwd: fa=%b fb=%b want 10 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_alu_chain();
        do_reset();
        set_id(1, 3, 1, 0, 1, 1, 1, 2, 0);          // add x3,x1,x2
        tick();
        set_id(1, 4, 1, 0, 1, 3, 1, 3, 0);          // sub x4,x3,x3
        vec_cnt++;
        if (ctl !== 4'b0000) begin
            err_cnt++; $display("FAIL chain_nostall: ctl=%b want 0000", ctl);
        end
        tick();
        vec_cnt++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            err_cnt++; $display("FAIL chain_fwd: fa=%b fb=%b want 01 01", fwd_a, fwd_b);
        end
    endtask

    task automatic test_younger_wins();
        do_reset();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 8, 1, 0, 1, 3, 1, 0, 0);          // or x8,x3,x0
        tick();
        vec_cnt++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            err_cnt++; $display("FAIL younger: fa=%b fb=%b want 01 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 0, 1, 1, 0, 0, 0, 0, 0);          // lw x0
        tick();
        set_id(1, 0, 1, 0, 1, 0, 1, 0, 0);          // addi x0 reading x0
        vec_cnt++;
        if (ctl !== 4'b0000) begin
            err_cnt++; $display("FAIL x0_nostall: ctl=%b want 0000", ctl);
        end
        tick();
        set_id(1, 9, 1, 0, 1, 0, 1, 0, 0);          // reader of x0 after two x0 writers
        tick();
        vec_cnt++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            err_cnt++; $display("FAIL x0_fwd: fa=%b fb=%b want 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_branch_override();
        do_reset();
        set_id(1, 5, 1, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 6, 1, 0, 1, 5, 0, 0, 1);          // load-use plus taken branch
        vec_cnt++;
        if (ctl !== 4'b0011) begin
            err_cnt++; $display("FAIL br_override: ctl=%b want 0011", ctl);
        end
        tick();
        vec_cnt++;
        if (stall_cnt !== 3'd0 || fwd_a !== 2'b00) begin
            err_cnt++; $display("FAIL br_cnt: cnt=%0d fa=%b want 0 00", stall_cnt, fwd_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CMAX + 2; i++) begin
            set_id(1, 5, 1, 1, 0, 0, 0, 0, 0);
            tick();
            set_id(1, 6, 1, 0, 0, 0, 1, 5, 0);
            tick();
            vec_cnt++;
            if (stall_cnt !== CW'((i + 1 > CMAX) ? CMAX : i + 1)) begin
                err_cnt++; $display("FAIL sat_cnt[%0d]: cnt=%0d want %0d", i, stall_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 5, 1, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 6, 1, 0, 1, 5, 0, 0, 0);
        vec_cnt++;
        if (ctl !== 4'b1101) begin
            err_cnt++; $display("FAIL mid_pre: ctl=%b want 1101", ctl);
        end
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        vec_cnt++;
        if (ctl !== 4'b0000 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 3'd0) begin
            err_cnt++; $display("FAIL mid_async: ctl=%b fa=%b fb=%b cnt=%0d want all 0", ctl, fwd_a, fwd_b, stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (ctl !== 4'b0000) begin
            err_cnt++; $display("FAIL mid_discard: ctl=%b want 0000", ctl);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 6)),
                   1'($urandom), $urandom_range(0, 2) == 0,
                   1'($urandom), 5'($urandom_range(0, 6)),
                   1'($urandom), 5'($urandom_range(0, 6)),
                   $urandom_range(0, 9) == 0);
            vec_cnt++;
            if (ctl !== m_ctl()) begin
                err_cnt++; $display("FAIL rnd_ctl[%0d]: ctl=%b want %b", n, ctl, m_ctl());
            end
            tick();
            vec_cnt++;
            if (fwd_a !== m_fa || fwd_b !== m_fb || stall_cnt !== CW'(m_cnt)) begin
                err_cnt++;
                $display("FAIL rnd_reg[%0d]: fa=%b fb=%b cnt=%0d want %b %b %0d", n, fwd_a, fwd_b, stall_cnt, m_fa, m_fb, m_cnt);
            end
        end
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_load_use();
        test_alu_chain();
        test_younger_wins();
        test_x0();
        test_branch_override();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ID_RS1, ID_RS2  input  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have ports ID_USES_RS1, ID_USES_RS2  input  1 each  source actually read by the ID instruction.
REQ-006 SHALL have port ID_RD  input  5  destination index of the ID instruction.
REQ-007 SHALL have ports ID_REG_WRITE, ID_MEM_READ  input  1 each  ID instruction writes rd, and is a load.
REQ-008 SHALL have port ID_VALID  input  1  ID holds a real instruction, not a bubble.
REQ-009 SHALL have port EXE_BRANCH_TAKEN  input  1  instruction in EXE redirects the PC this cycle.
REQ-010 SHALL have ports STALL_PC, STALL_IFID  output  1 each  hold the PC and the IF/ID register.
REQ-011 SHALL have ports FLUSH_IFID, FLUSH_IDEXE  output  1 each  load a bubble (all control zero) into IF/ID and ID/EX.
REQ-012 SHALL have ports FWD_A, FWD_B  output  2 each  ALU operand select for the EXE instruction: 00 ID/EX data, 01 EXE/MEM result, 10 MEM/WB data, 11 unused.
REQ-013 SHALL have port STALL_CNT  output  CNT_W  number of load-use stall cycles since reset.

Function
REQ-014 SHALL keep a three-entry tracker (EXE, MEM, WB); each entry holds valid, rd[4:0], reg_write and mem_read.
REQ-015 SHALL advance the tracker every clock: WB<=MEM, MEM<=EXE, EXE<=ID fields; the tracker never stalls.
REQ-016 SHALL load a bubble (all entry fields zero) into EXE instead of ID fields when ID_VALID=0, when FLUSH_IDEXE=1, or when a load-use stall is active.
REQ-017 SHALL treat a tracker entry as a producer only when valid=1, reg_write=1 and rd!=0; register x0 never causes a stall or a forward.
REQ-018 SHALL detect load-use combinationally: ID_VALID=1, EXE entry is a producer with mem_read=1, and (ID_USES_RS1 and ID_RS1==EXE.rd) or (ID_USES_RS2 and ID_RS2==EXE.rd).
REQ-019 SHALL, on load-use with EXE_BRANCH_TAKEN=0, drive STALL_PC=1, STALL_IFID=1 and FLUSH_IDEXE=1 in the same cycle; FLUSH_IFID=0.
REQ-020 SHALL, when EXE_BRANCH_TAKEN=1, drive FLUSH_IFID=1 and FLUSH_IDEXE=1 with STALL_PC=0 and STALL_IFID=0; the branch overrides any simultaneous load-use.
REQ-021 SHALL drive all four stall/flush outputs to 0 when neither condition holds.
REQ-022 SHALL keep each load-use stall to exactly one cycle: after the bubble, the load occupies MEM, so the condition clears on its own.
REQ-023 SHALL register FWD_A/FWD_B at the clock edge on which the ID instruction enters EXE; they are valid during that instruction's EXE cycle (latency 1).
REQ-024 SHALL compute next FWD_A as 01 if ID_USES_RS1 and ID_RS1 matches an EXE-entry producer; else 10 if it matches a MEM-entry producer; else 00. FWD_B SHALL be computed the same way from RS2.
REQ-025 SHALL give EXE-entry matches priority over MEM-entry matches (youngest producer wins).
REQ-026 SHALL register FWD_A=FWD_B=00 whenever a bubble enters EXE (REQ-016).
REQ-027 SHALL never forward from the WB entry; the register file is write-before-read, so it supplies that value directly.
REQ-028 SHALL increment STALL_CNT by 1 each cycle REQ-019 applies, and SHALL saturate at all-ones with no wrap-around.

Reset
REQ-029 SHALL, while rst=0, asynchronously clear all tracker entries, FWD_A, FWD_B and STALL_CNT to 0.
REQ-030 SHALL, while rst=0, hold STALL_PC, STALL_IFID, FLUSH_IFID and FLUSH_IDEXE at 0 regardless of other inputs.
REQ-031 SHALL resume on the first rising clk edge after rst returns high, with an empty tracker; reset mid-stall discards the pending stall.

Verification
REQ-032 SHALL pass: lw x5 then add x6,x5,x7 back-to-back -> one cycle with STALL_PC=STALL_IFID=FLUSH_IDEXE=1 and STALL_CNT=1; then add enters EXE with FWD_A=10.
REQ-033 SHALL pass: add x3,x1,x2 then sub x4,x3,x3 -> no stall; sub in EXE with FWD_A=01 and FWD_B=01.
REQ-034 SHALL pass: add x3; add x3; or x8,x3,x0 -> or in EXE with FWD_A=01 (younger producer), FWD_B=00.
REQ-035 SHALL pass: lw x0 followed by a reader of x0 -> no stall, FWD=00; any producer with rd=0 -> no forward.
REQ-036 SHALL pass: load-use and EXE_BRANCH_TAKEN=1 in the same cycle -> FLUSH_IFID=FLUSH_IDEXE=1, STALL_PC=0, STALL_CNT unchanged.
REQ-037 SHALL pass: STALL_CNT preloaded to 2^CNT_W-1 and a further stall -> count holds at all-ones; rst=0 asserted mid-stall -> all outputs 0 immediately, before the next clock edge.
